uart_frame_rx: RTL and testbench
================================

Name: uart_frame_rx

Overview:
- Serial receiver for the lab UART link; consumes the `txd` line produced by the frame transmitter.
- Frame format: start bit (0), 8 data bits LSB first, even parity bit, stop bit (1). That is 11 bit periods per frame.
- Recovers bytes by sampling at mid-bit, flags parity, framing and overrun errors, and presents each byte with a valid/ack handshake to downstream logic (message checker, LED/display sink).

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit period; legal range 4..65535.
- IDLE_LEVEL, 1'b1, line level when idle (start bit is its inverse, stop bit equals it).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rxd  input  1  serial line, asynchronous to clk.
- rx_data  output  8  last received byte.
- rx_valid  output  1  rx_data holds an unread byte.
- rx_ack  input  1  consumer accepts rx_data; honoured only while rx_valid=1.
- parity_err  output  1  parity mismatch on the byte in rx_data.
- frame_err  output  1  stop bit sampled as 0 on the byte in rx_data.
- overrun  output  1  sticky; a new byte completed while rx_valid=1.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
  - FSM=IDLE, synchroniser loaded with IDLE_LEVEL.
- Input path: rxd passes through a 2-FF synchroniser, giving rxd_s. All decisions use rxd_s, which adds 2 cycles of latency.
- Bit counter: a cycle counter of width clog2(CLKS_PER_BIT) counts 0..CLKS_PER_BIT-1 and wraps to 0.
- FSM states:
  - IDLE: when rxd_s != IDLE_LEVEL, go to START and clear the counter.
  - START: when counter = CLKS_PER_BIT/2 - 1, sample rxd_s.
    - If it is back at IDLE_LEVEL, treat as a glitch: return to IDLE with no outputs changed.
    - Otherwise go to DATA with bit_idx=0 and the counter cleared.
  - DATA: every CLKS_PER_BIT cycles, sample rxd_s into shift[bit_idx] (LSB first). After bit_idx=7, go to PARITY.
  - PARITY: after CLKS_PER_BIT cycles, sample the parity bit; go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample the stop bit, then complete the byte (see below).
    - If the stop bit = IDLE_LEVEL, go to IDLE.
    - Otherwise go to BREAK.
  - BREAK: wait until rxd_s = IDLE_LEVEL, then go to IDLE. No new start is detected while in BREAK.
- Byte completion (in the cycle after the STOP sample):
  - rx_data <= shift.
  - frame_err <= (stop != IDLE_LEVEL).
  - parity_err <= ((^shift ^ parity) != 0) when parity is enabled, else 0.
  - rx_valid <= 1.
  - If rx_valid was already 1 and rx_ack was not asserted in that cycle, set overrun <= 1. The new byte overwrites the old one.
- Handshake:
  - rx_ack with rx_valid=1 clears rx_valid in the next cycle.
  - rx_ack with rx_valid=0 is ignored.
  - Simultaneous completion and ack: the ack consumes the old byte, the new byte loads, rx_valid stays 1, and overrun does not set.
- overrun is cleared only by rst.
- busy=1 in every state except IDLE.
- Latency: rx_valid rises CLKS_PER_BIT/2 + 10*CLKS_PER_BIT + 3 cycles (±1) after the rxd start edge.
- Mid-frame line changes need no special handling; sampling only occurs at the counter points.
- rst asserted mid-frame aborts immediately. After reset release, a line held low causes a START detection; the bench must idle the line before release.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: 11-bit frame as described; PARITY state present; parity_err is live (even parity).
- Undefined: PARITY state removed, so DATA goes straight to STOP. Frame is 10 bits, parity_err is tied to 0, and latency shrinks by CLKS_PER_BIT.

Test Plan:
- Single byte (CLKS_PER_BIT=4, macro defined): send 0x61 as bits 0,1,0,0,0,0,1,1,0,1,1, then raise rx_ack one cycle after rx_valid. Expect rx_data=0x61, parity_err=0, frame_err=0, rx_valid high until the cycle after ack, busy low before the next frame.
- Stream: 16 back-to-back frames of "ala ma psa" padded with spaces (176 bit periods, no idle gaps), ack each byte immediately. Expect 16 bytes in order and overrun=0.
- Parity error: send 0x61 with the parity bit forced to 0. Expect rx_data=0x61 and parity_err=1. Send the next frame clean and expect parity_err=0.
- Framing/break: send 0x55 with the stop bit 0, then hold the line low for 20 bit periods. Expect frame_err=1, a single rx_valid pulse, busy=1 until the line returns high, and the next frame 0xA5 received correctly.
- Glitch and overrun: a 1-cycle low pulse on rxd produces no rx_valid. Then send two frames without ack: expect overrun=1 and rx_data equal to the second byte. Assert rst mid-frame: all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/uart_frame_rx_if.sv
// Handshake bundle between the UART frame receiver and its consumer.
// slave: receiver side (rxd/rx_ack in, byte + status out); master: consumer/driver.
interface uart_frame_rx_if;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport slave (
        input  rxd,
        input  rx_ack,
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output overrun,
        output busy
    );

    modport master (
        output rxd,
        output rx_ack,
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/uart_frame_rx.sv
// UART frame receiver: start, 8 data bits LSB first, [even parity], stop.
// Mid-bit sampling through a 2-FF synchroniser; byte handed off via valid/ack.
// Ports: clk, rst (async, active-high), bus (uart_frame_rx_if.slave):
//   rxd in, rx_ack in, rx_data/rx_valid/parity_err/frame_err/overrun/busy out.
// Optional: define UART_RX_PARITY_EN for the 11-bit frame with live parity_err;
// without it the frame is 10 bits and parity_err is tied to 0.
module uart_frame_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic        IDLE_LEVEL   = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    uart_frame_rx_if.slave bus
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t      r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic [CW-1:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
`ifdef UART_RX_PARITY_EN
    logic        r_par;
`endif
    logic        r_stop;
    logic        r_done;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_perr;
    logic        r_ferr;
    logic        r_ovr;
    logic        r_busy;

    logic        w_rxd_s;
    logic        w_tick_half;
    logic        w_tick_bit;

    assign w_rxd_s     = r_sync2;
    assign w_tick_half = (r_cnt == HALF_M1);
    assign w_tick_bit  = (r_cnt == FULL_M1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sync1   <= IDLE_LEVEL;
            r_sync2   <= IDLE_LEVEL;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
            r_par     <= 1'b0;
`endif
            r_stop    <= IDLE_LEVEL;
            r_done    <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_ovr     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_sync1 <= bus.rxd;
            r_sync2 <= r_sync1;
            r_done  <= 1'b0;
            r_cnt   <= w_tick_bit ? '0 : r_cnt + CW'(1);

            unique case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_rxd_s != IDLE_LEVEL) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    // Re-check the line half a bit in; a short pulse is a glitch.
                    if (w_tick_half) begin
                        r_cnt <= '0;
                        if (w_rxd_s == IDLE_LEVEL) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick_bit) begin
                        r_shift[r_bit_idx] <= w_rxd_s;
                        r_bit_idx          <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_tick_bit) begin
                        r_par   <= w_rxd_s;
                        r_state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_tick_bit) begin
                        r_stop <= w_rxd_s;
                        r_done <= 1'b1;
                        if (w_rxd_s == IDLE_LEVEL) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    // Line held at the start level: wait it out, no new start.
                    r_cnt <= '0;
                    if (w_rxd_s == IDLE_LEVEL) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Completion wins over ack; an ack in the same cycle just
            // consumes the old byte so overrun stays clear.
            if (r_done) begin
                r_data  <= r_shift;
                r_ferr  <= (r_stop != IDLE_LEVEL);
`ifdef UART_RX_PARITY_EN
                r_perr  <= ((^r_shift) ^ r_par);
`else
                r_perr  <= 1'b0;
`endif
                r_valid <= 1'b1;
                if (r_valid && !bus.rx_ack) begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && bus.rx_ack) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.rx_data    = r_data;
    assign bus.rx_valid   = r_valid;
    assign bus.parity_err = r_perr;
    assign bus.frame_err  = r_ferr;
    assign bus.overrun    = r_ovr;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx at CLKS_PER_BIT=4.
// Stimulus pushes expected bytes; a negedge monitor pops, compares and acks.
module tb_uart_frame_rx;

    localparam int   CPB  = 4;
    localparam logic IDLE = 1'b1;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ON = 1'b1;
`else
    localparam logic PAR_ON = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       ov;
    } exp_t;

    logic clk;
    logic rst;
    logic auto_ack;
    int   n_assert;
    int   n_fail;
    exp_t sb_q[$];

    uart_frame_rx_if bus();

    uart_frame_rx #(
        .CLKS_PER_BIT(CPB),
        .IDLE_LEVEL  (IDLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_force,
                              input logic par_val, input logic stop_bit);
        send_bit(~IDLE);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_force ? par_val : ^d);
`endif
        send_bit(stop_bit);
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic pe,
                               input logic fe, input logic ov);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        e.ov = ov;
        sb_q.push_back(e);
    endtask

    // Monitor: compares on each rising rx_valid, acks when enabled.
    initial begin
        logic prev_v;
        logic ack_chk;
        exp_t e;
        prev_v     = 1'b0;
        ack_chk    = 1'b0;
        bus.rx_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.rx_ack = 1'b0;
                prev_v     = 1'b0;
                ack_chk    = 1'b0;
            end else begin
                if (ack_chk) begin
                    check("valid_after_ack", bus.rx_valid, 0);
                    ack_chk = 1'b0;
                end
                if (bus.rx_valid && !prev_v) begin
                    if (sb_q.size() == 0) begin
                        n_assert++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %0h expected none",
                                 bus.rx_data);
                    end else begin
                        e = sb_q.pop_front();
                        check("rx_data", bus.rx_data, e.d);
                        check("parity_err", bus.parity_err, e.pe);
                        check("frame_err", bus.frame_err, e.fe);
                        check("overrun", bus.overrun, e.ov);
                    end
                end
                if (auto_ack && bus.rx_valid && !bus.rx_ack) begin
                    bus.rx_ack = 1'b1;
                    ack_chk    = 1'b1;
                end else begin
                    bus.rx_ack = 1'b0;
                end
                prev_v = bus.rx_valid;
            end
        end
    end

    logic [7:0] msg [16];

    initial begin
        msg = '{8'h61, 8'h6C, 8'h61, 8'h20, 8'h6D, 8'h61, 8'h20, 8'h70,
                8'h73, 8'h61, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};
        n_assert = 0;
        n_fail   = 0;
        auto_ack = 1'b1;
        rst      = 1'b1;
        bus.rxd  = IDLE;
        repeat (3) @(negedge clk);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_flags", {bus.parity_err, bus.frame_err, bus.overrun}, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte 0x61
        expect_byte(8'h61, 1'b0, 1'b0, 1'b0);
        send_frame(8'h61, 1'b0, 1'b0, IDLE);
        repeat (2 * CPB) @(negedge clk);
        check("busy_idle_1", bus.busy, 0);

        // Back-to-back stream
        for (int i = 0; i < 16; i++) begin
            expect_byte(msg[i], 1'b0, 1'b0, 1'b0);
            send_frame(msg[i], 1'b0, 1'b0, IDLE);
        end
        repeat (2 * CPB) @(negedge clk);
        check("stream_overrun", bus.overrun, 0);

        // Parity error then a clean frame
        expect_byte(8'h61, PAR_ON, 1'b0, 1'b0);
        send_frame(8'h61, 1'b1, 1'b0, IDLE);
        expect_byte(8'h62, 1'b0, 1'b0, 1'b0);
        send_frame(8'h62, 1'b0, 1'b0, IDLE);
        repeat (2 * CPB) @(negedge clk);

        // Framing error followed by a break
        expect_byte(8'h55, 1'b0, 1'b1, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0, ~IDLE);
        bus.rxd = ~IDLE;
        repeat (20 * CPB) @(negedge clk);
        check("break_busy", bus.busy, 1);
        bus.rxd = IDLE;
        repeat (2 * CPB) @(negedge clk);
        check("break_released", bus.busy, 0);
        expect_byte(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, IDLE);
        repeat (2 * CPB) @(negedge clk);

        // One-cycle glitch
        bus.rxd = ~IDLE;
        @(negedge clk);
        bus.rxd = IDLE;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_valid", bus.rx_valid, 0);
        check("glitch_busy", bus.busy, 0);

        // Overrun: two bytes, no ack
        auto_ack = 1'b0;
        expect_byte(8'h12, 1'b0, 1'b0, 1'b0);
        send_frame(8'h12, 1'b0, 1'b0, IDLE);
        send_frame(8'h34, 1'b0, 1'b0, IDLE);
        repeat (2 * CPB) @(negedge clk);
        check("ovr_data", bus.rx_data, 8'h34);
        check("ovr_flag", bus.overrun, 1);
        check("ovr_valid", bus.rx_valid, 1);

        // Reset in the middle of a frame
        send_bit(~IDLE);
        send_bit(1'b1);
        send_bit(1'b0);
        check("mid_busy", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", bus.rx_valid, 0);
        check("arst_data", bus.rx_data, 0);
        check("arst_overrun", bus.overrun, 0);
        check("arst_errs", {bus.parity_err, bus.frame_err}, 0);
        check("arst_busy", bus.busy, 0);
        bus.rxd = IDLE;
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        auto_ack = 1'b1;
        repeat (4) @(negedge clk);
        expect_byte(8'h7E, 1'b0, 1'b0, 1'b0);
        send_frame(8'h7E, 1'b0, 1'b0, IDLE);

        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("queue_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
